// File: rtl/taxi_eth_pause_pkg.sv
// Shared constants and types for the receive-side pause timer bank.
// Quanta timing is expressed in enabled datapath cycles.
package taxi_eth_pause_pkg;

  localparam int QUANTA_BITS = 512;

  typedef enum logic {
    SEL_PFC = 1'b0,
    SEL_LFC = 1'b1
  } load_sel_e;

  function automatic int quanta_cycles(input int data_w);
    return QUANTA_BITS / data_w;
  endfunction

endpackage

// File: rtl/taxi_eth_pause_quanta_chan.sv
// One priority channel: quanta counter, prescaler and status strobes.
// pause_req tracks the next counter value so it rises right after a load.
module taxi_eth_pause_quanta_chan #(
  parameter int QUANTA_W = 16,
  parameter int CNT_W    = 16,
  parameter int Q        = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clk_en,
  input  logic                i_load,
  input  logic [QUANTA_W-1:0] i_val,
  input  logic                i_en,
  input  logic                i_ack,
  output logic                o_req,
  output logic                o_xoff,
  output logic                o_xon,
  output logic                o_paused
);

  import taxi_eth_pause_pkg::*;

  localparam int PRE_W = $clog2(Q);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             w_clr;
  logic             w_ld;
  logic             w_tick;
  logic             w_wrap;
  logic             r_req;
  logic             r_xoff;
  logic             r_xon;
  logic             r_paused;

  assign w_clr  = ~i_en;
  assign w_ld   = i_en & i_load;
  assign w_tick = i_en & ~i_load
                & (r_cnt != '0) & i_clk_en;
  assign w_wrap = (r_pre == PRE_W'(Q - 1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_pre_nxt = r_pre;
    unique case (1'b1)
      w_clr: begin
        w_cnt_nxt = '0;
        w_pre_nxt = '0;
      end
      w_ld: begin
        w_cnt_nxt = CNT_W'(i_val);
        w_pre_nxt = '0;
      end
      w_tick: begin
        if (w_wrap) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          w_pre_nxt = '0;
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pre    <= '0;
      r_req    <= 1'b0;
      r_xoff   <= 1'b0;
      r_xon    <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_pre    <= w_pre_nxt;
      r_req    <= (w_cnt_nxt != '0);
      r_xoff   <= w_ld & (|i_val);
      r_xon    <= w_ld & ~(|i_val);
      r_paused <= r_req & i_ack;
    end
  end

  assign o_req    = r_req;
  assign o_xoff   = r_xoff;
  assign o_xon    = r_xon;
  assign o_paused = r_paused;

endmodule

// File: rtl/taxi_eth_pause_quanta_timer.sv
// Pause timer bank: decodes LFC/PFC requests into per-priority loads
// and runs one quanta countdown per priority channel.
module taxi_eth_pause_quanta_timer #(
  parameter int PRIO_CNT = 8,
  parameter int QUANTA_W = 16,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = QUANTA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         req_valid,
  input  logic                         req_lfc,
  input  logic [PRIO_CNT-1:0]          req_prio_mask,
  input  logic [PRIO_CNT*QUANTA_W-1:0] req_quanta,
  input  logic [PRIO_CNT-1:0]          pause_en,
  output logic [PRIO_CNT-1:0]          pause_req,
  input  logic [PRIO_CNT-1:0]          pause_ack,
  output logic [PRIO_CNT-1:0]          stat_xoff,
  output logic [PRIO_CNT-1:0]          stat_xon,
  output logic [PRIO_CNT-1:0]          stat_paused
);

  import taxi_eth_pause_pkg::*;

  localparam int Q = quanta_cycles(DATA_W);

  if (!(DATA_W == 8 || DATA_W == 16 ||
        DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("DATA_W must be 8, 16, 32 or 64");
  end
  if (PRIO_CNT < 1 || PRIO_CNT > 8) begin : g_bad_prio
    $error("PRIO_CNT must be 1..8");
  end
  if (CNT_W < QUANTA_W) begin : g_bad_cnt_w
    $error("CNT_W must be >= QUANTA_W");
  end

  load_sel_e w_mode;

  assign w_mode = req_lfc ? SEL_LFC : SEL_PFC;

  for (genvar i = 0; i < PRIO_CNT; i++) begin : g_chan
    logic                w_sel;
    logic [QUANTA_W-1:0] w_val;

    // LFC broadcasts slot 0 and ignores the priority mask
    assign w_sel = req_valid & pause_en[i]
                 & ((w_mode == SEL_LFC) | req_prio_mask[i]);
    assign w_val = (w_mode == SEL_LFC)
                 ? req_quanta[0 +: QUANTA_W]
                 : req_quanta[i*QUANTA_W +: QUANTA_W];

    taxi_eth_pause_quanta_chan #(
      .QUANTA_W (QUANTA_W),
      .CNT_W    (CNT_W),
      .Q        (Q)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clk_en (clk_en),
      .i_load   (w_sel),
      .i_val    (w_val),
      .i_en     (pause_en[i]),
      .i_ack    (pause_ack[i]),
      .o_req    (pause_req[i]),
      .o_xoff   (stat_xoff[i]),
      .o_xon    (stat_xon[i]),
      .o_paused (stat_paused[i])
    );
  end

endmodule

// File: tb/tb_taxi_eth_pause_quanta_timer.sv
// Scoreboard bench: DATA_W=8 and DATA_W=64 instances share stimulus and
// are checked each cycle against a remaining-enabled-cycles model.
module tb_taxi_eth_pause_quanta_timer;

  typedef struct packed {
    logic [1:0][7:0] req;
    logic [1:0][7:0] xoff;
    logic [1:0][7:0] xon;
    logic [1:0][7:0] pd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clk_en;
  logic         req_valid;
  logic         req_lfc;
  logic [7:0]   req_prio_mask;
  logic [127:0] req_quanta;
  logic [7:0]   pause_en;
  logic [7:0]   pause_ack;
  logic [15:0]  slot [8];

  logic [7:0] req8, xoff8, xon8, pd8;
  logic [7:0] req64, xoff64, xon64, pd64;

  exp_t sb[$];
  int   rem [2][8];
  logic [1:0][7:0] cur;
  int   errors = 0;
  int   checks = 0;
  int   tick = 0;
  int   en_mode = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_quanta = '0;
    for (int i = 0; i < 8; i++) req_quanta[i*16 +: 16] = slot[i];
  end

  taxi_eth_pause_quanta_timer #(
    .PRIO_CNT(8), .QUANTA_W(16), .DATA_W(8), .CNT_W(16)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_lfc(req_lfc),
    .req_prio_mask(req_prio_mask), .req_quanta(req_quanta),
    .pause_en(pause_en), .pause_req(req8), .pause_ack(pause_ack),
    .stat_xoff(xoff8), .stat_xon(xon8), .stat_paused(pd8)
  );

  taxi_eth_pause_quanta_timer #(
    .PRIO_CNT(8), .QUANTA_W(16), .DATA_W(64), .CNT_W(16)
  ) dut64 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_lfc(req_lfc),
    .req_prio_mask(req_prio_mask), .req_quanta(req_quanta),
    .pause_en(pause_en), .pause_req(req64), .pause_ack(pause_ack),
    .stat_xoff(xoff64), .stat_xon(xon64), .stat_paused(pd64)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Pause lasts V*Q enabled cycles from the load; held as a plain count.
  task automatic model(output exp_t e);
    int   qd;
    int   v;
    logic sel;
    e = '0;
    for (int d = 0; d < 2; d++) begin
      qd = (d == 0) ? 64 : 8;
      for (int c = 0; c < 8; c++) begin
        sel = req_valid && pause_en[c] && (req_lfc || req_prio_mask[c]);
        v = req_lfc ? int'(slot[0]) : int'(slot[c]);
        e.pd[d][c] = cur[d][c] & pause_ack[c];
        if (!pause_en[c]) rem[d][c] = 0;
        else if (sel) rem[d][c] = v * qd;
        else if (rem[d][c] > 0 && clk_en) rem[d][c]--;
        e.req[d][c]  = rem[d][c] > 0;
        e.xoff[d][c] = sel && v != 0;
        e.xon[d][c]  = sel && v == 0;
      end
    end
    cur = e.req;
  endtask

  task automatic cyc();
    exp_t e;
    if (en_mode == 0) clk_en = 1'b1;
    else if (en_mode > 0) clk_en = (tick % en_mode) == 0;
    else clk_en = ($urandom_range(3) != 0);
    tick++;
    model(e);
    @(posedge clk);
    sb.push_back(e);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic req(input logic lfc, input logic [7:0] mask);
    req_valid = 1'b1;
    req_lfc = lfc;
    req_prio_mask = mask;
    cyc();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req8", req8, 8'h0);
    chk("rst_req64", req64, 8'h0);
    chk("rst_stat8", xoff8 | xon8 | pd8, 8'h0);
    chk("rst_stat64", xoff64 | xon64 | pd64, 8'h0);
    sb.delete();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 8; c++) rem[d][c] = 0;
    cur = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("hold_req8", req8, 8'h0);
        chk("hold_req64", req64, 8'h0);
        chk("hold_stat8", xoff8 | xon8 | pd8, 8'h0);
        chk("hold_stat64", xoff64 | xon64 | pd64, 8'h0);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("req8", req8, e.req[0]);
        chk("xoff8", xoff8, e.xoff[0]);
        chk("xon8", xon8, e.xon[0]);
        chk("paused8", pd8, e.pd[0]);
        chk("req64", req64, e.req[1]);
        chk("xoff64", xoff64, e.xoff[1]);
        chk("xon64", xon64, e.xon[1]);
        chk("paused64", pd64, e.pd[1]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clk_en = 1'b0;
    req_valid = 1'b0;
    req_lfc = 1'b0;
    req_prio_mask = '0;
    pause_en = 8'hFF;
    pause_ack = '0;
    cur = '0;
    for (int i = 0; i < 8; i++) slot[i] = '0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 8; c++) rem[d][c] = 0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    slot[3] = 16'd2;
    req(1'b0, 8'h08);
    idle(140);

    slot[0] = 16'd1;
    req(1'b1, 8'h00);
    idle(70);
    pause_en = 8'hFE;
    idle(1);
    req(1'b1, 8'h00);
    idle(70);
    pause_en = 8'hFF;

    en_mode = 10;
    slot[0] = 16'd3;
    req(1'b0, 8'h01);
    idle(2000);
    en_mode = 0;

    slot[5] = 16'd4;
    req(1'b0, 8'h20);
    idle(99);
    slot[5] = 16'd1;
    req(1'b0, 8'h20);
    idle(80);
    slot[5] = 16'd4;
    req(1'b0, 8'h20);
    idle(99);
    slot[5] = 16'd0;
    req(1'b0, 8'h20);
    idle(5);

    slot[2] = 16'd1;
    req(1'b0, 8'h04);
    idle(63);
    slot[2] = 16'd2;
    req(1'b0, 8'h04);
    idle(20);
    pause_ack = 8'h04;
    idle(150);
    pause_ack = '0;

    for (int i = 0; i < 8; i++) slot[i] = 16'd3;
    req(1'b0, 8'hFF);
    idle(30);
    do_reset();
    idle(20);

    en_mode = -1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if ($urandom_range(63) == 0) pause_en = 8'($urandom);
      else if ($urandom_range(15) == 0) pause_en = 8'hFF;
      if ($urandom_range(7) == 0) pause_ack = 8'($urandom);
      if ($urandom_range(15) == 0) begin
        for (int i = 0; i < 8; i++) slot[i] = 16'($urandom_range(3));
        req_valid = 1'b1;
        req_lfc = ($urandom_range(3) == 0);
        req_prio_mask = 8'($urandom);
      end
      cyc();
    end
    en_mode = 0;
    idle(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
